// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: PS/2 keyboard receiver feeding a first-word-fall-through
// scan-code FIFO for the CPU memory-mapped IO read path.
//
// Ports:
//   clk, rstn     system clock, asynchronous active-low reset
//   ps2_clk       raw PS/2 clock pin (asynchronous)
//   ps2_data      raw PS/2 data pin (asynchronous)
//   rd_en         pop strobe, one entry per cycle high (ignored when empty)
//   ovf_clr       clears the sticky overflow flag
//   rd_data       head-of-FIFO scan code
//   rd_ext        head entry was preceded by E0
//   empty, full   FIFO status
//   count         FIFO occupancy (0..FIFO_DEPTH)
//   frame_err     one-cycle pulse on a bad or timed-out frame
//   overflow      sticky: a make code was dropped because the FIFO was full
//
// Optional feature: define PS2_HEX_DECODE_EN to translate make codes of the
// keys 0-9/A-F into hex digits before queuing; every other code, and any
// E0-extended code, is then discarded.

module ps2_scan_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rd_en,
    input  logic                        ovf_clr,
    output logic [7:0]                  rd_data,
    output logic                        rd_ext,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } entry_t;

    // Pin synchronisers, idle bus level is high
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_c = clk_prev_q & ~clk_s2_q;

    // Deframer state
    state_e             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [9:0]         shreg_q, shreg_d;
    logic               ext_q, ext_d;
    logic               brk_q, brk_d;
    logic               frame_err_q, frame_err_d;
    logic               push_c;
    entry_t             push_entry_c;
    logic [7:0]         code_c;
    logic               frame_ok_c;

    // shreg fills from the top: data[7:0], parity at [8], stop at [9]
    assign code_c     = shreg_q[7:0];
    assign frame_ok_c = (^shreg_q[8:0]) & shreg_q[9];

`ifdef PS2_HEX_DECODE_EN
    logic       hex_hit_c;
    logic [3:0] hex_val_c;

    // Make-code to hex-digit lookup
    always_comb begin
        hex_hit_c = 1'b1;
        hex_val_c = 4'h0;
        case (code_c)
            8'h45: hex_val_c = 4'h0;
            8'h16: hex_val_c = 4'h1;
            8'h1E: hex_val_c = 4'h2;
            8'h26: hex_val_c = 4'h3;
            8'h25: hex_val_c = 4'h4;
            8'h2E: hex_val_c = 4'h5;
            8'h36: hex_val_c = 4'h6;
            8'h3D: hex_val_c = 4'h7;
            8'h3E: hex_val_c = 4'h8;
            8'h46: hex_val_c = 4'h9;
            8'h1C: hex_val_c = 4'hA;
            8'h32: hex_val_c = 4'hB;
            8'h21: hex_val_c = 4'hC;
            8'h23: hex_val_c = 4'hD;
            8'h24: hex_val_c = 4'hE;
            8'h2B: hex_val_c = 4'hF;
            default: hex_hit_c = 1'b0;
        endcase
    end
`endif

    // Deframer next-state and code filtering
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        shreg_d      = shreg_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        frame_err_d  = 1'b0;
        push_c       = 1'b0;
        push_entry_c = '0;

        case (state_q)
            S_IDLE: begin
                if (fall_c && !dat_s2_q) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = 4'd0;
                    timer_d   = '0;
                end
            end

            S_SHIFT: begin
                if (fall_c) begin
                    shreg_d   = {dat_s2_q, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    timer_d   = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_CHECK;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon partial frame; prefix flags survive a timeout
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_CHECK: begin
                state_d = S_IDLE;
                if (!frame_ok_c) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end else if (code_c == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (code_c == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    ext_d = 1'b0;
`ifdef PS2_HEX_DECODE_EN
                    if (!ext_q && hex_hit_c) begin
                        push_c            = 1'b1;
                        push_entry_c.ext  = 1'b0;
                        push_entry_c.code = {4'b0000, hex_val_c};
                    end
`else
                    push_c            = 1'b1;
                    push_entry_c.ext  = ext_q;
                    push_entry_c.code = code_c;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            timer_q     <= '0;
            shreg_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            shreg_q     <= shreg_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
        end
    end

    // FWFT FIFO
    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             pop_c, wr_c, drop_c, full_c;

    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c  = rd_en & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs
    assign wr_c   = push_c & (~full_c | pop_c);
    assign drop_c = push_c & full_c & ~pop_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                mem_q[wr_ptr_q] <= push_entry_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Set wins over clear
            if (drop_c) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign rd_data   = mem_q[rd_ptr_q].code;
    assign rd_ext    = mem_q[rd_ptr_q].ext;
    assign empty     = (count_q == '0);
    assign full      = full_c;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
